// File: rtl/rim_maze_solver.sv
// Rat-in-maze path finder for a fixed 8x8 maze. Rows are loaded over 8 cycles,
// reachability toward (7,7) is computed in one cycle, and the right-first
// monotone path from (0,0) is streamed out as 15 (row, col) pairs.
module rim_maze_solver (
  input  logic       clk,
  input  logic       rst_n,     // synchronous, active-high despite the name
  input  logic       in_valid,
  input  logic [7:0] maze,      // maze[7] = column 0, maze[0] = column 7
  output logic       out_valid,
  output logic [2:0] out_row,
  output logic [2:0] out_col
);

  typedef enum logic [1:0] {StIdle, StLoad, StSolve, StOutput} state_e;

  state_e            state_q, state_d;
  logic [7:0][7:0]   maze_q;     // maze_q[r] holds row r in input bit order
  logic [2:0]        row_q;
  // Column 8 / row 8 are permanently-false padding so neighbours never go out of range.
  logic [8:0][8:0]   reach_c;
  logic [7:0][8:0]   reach_q;
  logic [2:0]        cur_r_q, cur_c_q;
  logic [3:0]        step_q;
  logic              go_right;

  // Backward reachability: a cell reaches (7,7) if open and its right or down neighbour does.
  always_comb begin
    reach_c = '0;
    for (int r = 7; r >= 0; r--) begin
      for (int c = 7; c >= 0; c--) begin
        reach_c[r][c] = maze_q[r][7-c] &
                        (((r == 7) && (c == 7)) | reach_c[r][c+1] | reach_c[r+1][c]);
      end
    end
  end

  // Right-first step decision for the current path cell.
  always_comb begin
    go_right = reach_q[cur_r_q][{1'b0, cur_c_q} + 4'd1];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (in_valid) state_d = StLoad;
      StLoad:   if (in_valid && (row_q == 3'd7)) state_d = StSolve;
      StSolve:  state_d = StOutput;
      StOutput: if (step_q == 4'd14) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register, maze capture, reachability latch and path walker.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= StIdle;
      maze_q  <= '0;
      reach_q <= '0;
      row_q   <= '0;
      cur_r_q <= '0;
      cur_c_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            maze_q[0] <= maze;
            row_q     <= 3'd1;
          end
        end
        StLoad: begin
          if (in_valid) begin
            maze_q[row_q] <= maze;
            row_q         <= row_q + 3'd1;
          end
        end
        StSolve: begin
          reach_q <= reach_c[7:0];
          cur_r_q <= '0;
          cur_c_q <= '0;
          step_q  <= '0;
        end
        StOutput: begin
          step_q <= step_q + 4'd1;
          if (step_q == 4'd14) begin
            cur_r_q <= '0;
            cur_c_q <= '0;
          end else if (go_right) begin
            cur_c_q <= cur_c_q + 3'd1;
          end else if (cur_r_q != 3'd7) begin
            // Saturate so an unsolvable maze still terminates cleanly.
            cur_r_q <= cur_r_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced to zero outside the path stream.
  always_comb begin
    out_valid = (state_q == StOutput);
    out_row   = out_valid ? cur_r_q : 3'd0;
    out_col   = out_valid ? cur_c_q : 3'd0;
  end

endmodule

// File: tb/tb_rim_maze_solver.sv
// Directed bench for rim_maze_solver: hand-derived paths for structured mazes,
// random solvable mazes against a forward-flood model, and a mid-output reset.
module tb_rim_maze_solver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] maze;
  logic       out_valid;
  logic [2:0] out_row;
  logic [2:0] out_col;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rows [8];
  int         exp_r [15];
  int         exp_c [15];

  rim_maze_solver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .maze     (maze),
    .out_valid(out_valid),
    .out_row  (out_row),
    .out_col  (out_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive rows[0..7] on consecutive cycles; inputs change on falling edges.
  task automatic send_maze();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      maze     = rows[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    maze     = 8'h00;
  endtask

  // Wait (bounded) for out_valid, then compare the 15-cell stream and the idle cycle after.
  task automatic check_path(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 199) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " out_valid rises"}, {31'd0, out_valid}, 32'd1);
    if (out_valid === 1'b1) begin
      for (int k = 0; k < 15; k++) begin
        chk($sformatf("%s valid[%0d]", tag, k), {31'd0, out_valid}, 32'd1);
        chk($sformatf("%s row[%0d]", tag, k), {29'd0, out_row}, exp_r[k]);
        chk($sformatf("%s col[%0d]", tag, k), {29'd0, out_col}, exp_c[k]);
        @(negedge clk);
      end
      chk({tag, " valid after"}, {31'd0, out_valid}, 32'd0);
      chk({tag, " row after"}, {29'd0, out_row}, 32'd0);
      chk({tag, " col after"}, {29'd0, out_col}, 32'd0);
    end
  endtask

  // Forward flood from (sr,sc) restricted to right/down moves; true if (7,7) is hit.
  function automatic bit reaches_goal(int sr, int sc);
    bit v [8][8];
    bit o, up, left;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) v[r][c] = 1'b0;
    for (int r = sr; r < 8; r++) begin
      for (int c = sc; c < 8; c++) begin
        o    = rows[r][7-c];
        up   = (r > sr) ? v[r-1][c] : 1'b0;
        left = (c > sc) ? v[r][c-1] : 1'b0;
        v[r][c] = ((r == sr) && (c == sc)) ? o : (o & (up | left));
      end
    end
    return v[7][7];
  endfunction

  task automatic model_path();
    int r = 0;
    int c = 0;
    for (int k = 0; k < 15; k++) begin
      exp_r[k] = r;
      exp_c[k] = c;
      if (c < 7 && reaches_goal(r, c + 1)) c++;
      else r++;
    end
  endtask

  // Random maze with a randomly-chosen monotone path carved open.
  task automatic random_maze();
    int r = 0;
    int c = 0;
    for (int i = 0; i < 8; i++) rows[i] = 8'($urandom);
    rows[0][7] = 1'b1;
    while (!(r == 7 && c == 7)) begin
      if (r == 7) c++;
      else if (c == 7) r++;
      else if ($urandom_range(1, 0) == 1) c++;
      else r++;
      rows[r][7-c] = 1'b1;
    end
  endtask

  // Right along row 0, then down column 7.
  task automatic exp_right_then_down();
    for (int k = 0; k < 15; k++) begin
      exp_r[k] = (k < 8) ? 0 : k - 7;
      exp_c[k] = (k < 8) ? k : 7;
    end
  endtask

  // Down column 0, then right along row 7.
  task automatic exp_down_then_right();
    for (int k = 0; k < 15; k++) begin
      exp_r[k] = (k < 8) ? k : 7;
      exp_c[k] = (k < 8) ? 0 : k - 7;
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    maze     = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_row", {29'd0, out_row}, 32'd0);
    chk("reset out_col", {29'd0, out_col}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);

    // All open.
    for (int i = 0; i < 8; i++) rows[i] = 8'hFF;
    exp_right_then_down();
    send_maze();
    chk("open pre valid", {31'd0, out_valid}, 32'd0);
    check_path("open");
    repeat (2) @(negedge clk);

    // Column 0 and row 7 only.
    for (int i = 0; i < 7; i++) rows[i] = 8'h80;
    rows[7] = 8'hFF;
    exp_down_then_right();
    send_maze();
    check_path("lshape");
    repeat (2) @(negedge clk);

    // Staircase: row i open at columns i and i+1.
    for (int i = 0; i < 8; i++) rows[i] = 8'hC0 >> i;
    for (int k = 0; k < 15; k++) begin
      exp_r[k] = k / 2;
      exp_c[k] = (k + 1) / 2;
    end
    send_maze();
    check_path("stair");
    repeat (2) @(negedge clk);

    // Dead-end trap along rows 0/1 to the right; only column 0 leads home.
    rows[0] = 8'hFC;
    rows[1] = 8'hF8;
    for (int i = 2; i < 7; i++) rows[i] = 8'h80;
    rows[7] = 8'hFF;
    exp_down_then_right();
    send_maze();
    check_path("trap");
    repeat (2) @(negedge clk);

    // Random solvable mazes, back to back.
    for (int t = 0; t < 100; t++) begin
      random_maze();
      model_path();
      send_maze();
      check_path($sformatf("rand%0d", t));
      @(negedge clk);
    end

    // Reset during output cycle 5, then a clean solve.
    for (int i = 0; i < 8; i++) rows[i] = 8'hFF;
    send_maze();
    begin
      int n = 0;
      while (out_valid !== 1'b1 && n < 199) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rst out_valid rises", {31'd0, out_valid}, 32'd1);
    repeat (5) @(negedge clk);
    chk("rst cycle5 col", {29'd0, out_col}, 32'd5);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst valid", {31'd0, out_valid}, 32'd0);
    chk("rst row", {29'd0, out_row}, 32'd0);
    chk("rst col", {29'd0, out_col}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) rows[i] = 8'h80;
    rows[7] = 8'hFF;
    exp_down_then_right();
    send_maze();
    check_path("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
